// File: rtl/stream_min_max_finder.sv
// ----------------------------------------------------------------------------
// stream_min_max_finder
//
// Collects a frame of N unsigned WIDTH-bit samples from a valid/ready stream
// and reports either the smallest (mode=0) or the largest (mode=1) sample,
// together with the frame position of its first occurrence. The result is
// presented zero-extended to OUT_WIDTH bits on a valid/ready output port.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active-low
//   start      begin a frame (only looked at while idle)
//   mode       0 = minimum, 1 = maximum; captured when start is accepted
//   in_valid   in_data carries a sample
//   in_data    sample, WIDTH bits unsigned
//   in_ready   a sample is accepted this cycle if in_valid is also high
//   out_valid  result available
//   out_ready  consumer takes the result
//   out_value  zero-extended best sample
//   out_index  position (0..N-1) of the first best sample in the frame
//   busy       a frame is being collected or its result is pending
// ----------------------------------------------------------------------------
module stream_min_max_finder #(
    parameter  int WIDTH     = 4,
    parameter  int N         = 4,
    parameter  int OUT_WIDTH = 8,
    localparam int IDXW      = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_value,
    output logic [IDXW-1:0]      out_index,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [IDXW-1:0]   count;
    logic [WIDTH-1:0]  best;
    logic [IDXW-1:0]   index;
    logic              mode_q;
    logic [WIDTH-1:0]  res_value;
    logic [IDXW-1:0]   res_index;

    logic              last;
    logic              take;
    logic [WIDTH-1:0]  cand_best;
    logic [IDXW-1:0]   cand_index;

    // Candidate running result if the sample on in_data is accepted now.
    // Strict compares keep the earliest index on ties.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        take       = 1'b0;
        cand_best  = best;
        cand_index = index;
        last       = (count == IDXW'(N - 1));
        if (count == '0) begin
            take = 1'b1;
        end else if (mode_q) begin
            take = (in_data > best);
        end else begin
            take = (in_data < best);
        end
        if (take) begin
            cand_best  = in_data;
            cand_index = count;
        end
    end

    // Handshake flags decode from state only.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // The result registers are only loaded on entry to DONE, so the
    // outputs keep the previous result while the next frame accumulates.
    assign out_value = OUT_WIDTH'(res_value);
    assign out_index = res_index;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register, datapath included, is cleared by reset so
        // all outputs read zero during reset and a partial frame is dropped.
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            best      <= '0;
            index     <= '0;
            mode_q    <= 1'b0;
            res_value <= '0;
            res_index <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        count  <= '0;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        best  <= cand_best;
                        index <= cand_index;
                        if (last) begin
                            res_value <= cand_best;
                            res_index <= cand_index;
                            count     <= '0;
                            state     <= DONE;
                        end else begin
                            count <= count + IDXW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
